// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/pipeline-control unit: stage indices, forwarding
// select encodings and the EX..WB shadow entry.
package hazard_pkg;

  localparam int unsigned ST_PC  = 0;
  localparam int unsigned ST_IF  = 1;
  localparam int unsigned ST_ID  = 2;
  localparam int unsigned ST_EX  = 3;
  localparam int unsigned ST_MEM = 4;
  localparam int unsigned ST_WB  = 5;

  // Widest register address / stage index a shadow entry can hold.
  localparam int unsigned MAX_AW  = 8;
  localparam int unsigned STAGE_W = 4;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [MAX_AW-1:0]  waddr;
    logic [STAGE_W-1:0] avail;
  } entry_t;

  // Forwarding source for a producer currently sitting in `stage` (anything past MEM is WB).
  function automatic logic [1:0] fwd_code(input int unsigned stage);
    if (stage >= ST_WB) return FWD_WB;
    if (stage == ST_MEM) return FWD_MEM;
    return FWD_EX;
  endfunction

endpackage

// File: rtl/hazard_fwd_port.sv
// Match and youngest-wins priority for one ID read port against the EX..WB shadow entries.
module hazard_fwd_port
  import hazard_pkg::*;
#(
  parameter int unsigned NE     = 3,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0]       raddr,
  input  logic                    rvalid,
  input  logic [NE-1:0]           ent_live,
  input  logic [NE*MAX_AW-1:0]    ent_waddr,
  input  logic [NE*STAGE_W-1:0]   ent_avail,
  output logic [1:0]              sel,
  output logic                    hazard
);

  logic found;

  // Entry 0 is EX, the youngest producer, so the first hit wins.
  always_comb begin
    sel    = FWD_RF;
    hazard = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (!found && rvalid && raddr != '0 && ent_live[i] &&
          ent_waddr[i*MAX_AW +: MAX_AW] == MAX_AW'(raddr)) begin
        found = 1'b1;
        if (ST_EX + i >= 32'(ent_avail[i*STAGE_W +: STAGE_W])) begin
          sel = fwd_code(ST_EX + i);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and pipeline-control unit: shadows EX..WB destinations, drives ID forwarding
// selects and the per-stage stall bus for load-use, multi-cycle EX ops and flushes.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_STAGE = 4,
  parameter int unsigned MC_LAT     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NREAD*REG_AW-1:0]  id_raddr,
  input  logic [NREAD-1:0]         id_rvalid,
  input  logic                     id_we,
  input  logic [REG_AW-1:0]        id_waddr,
  input  logic                     id_ld,
  input  logic                     id_mc,
  input  logic                     flush,
  output logic [NUM_STAGES:0]      stall,
  output logic [NREAD*2-1:0]       fwd_sel,
  output logic                     stall_load,
  output logic                     mc_busy
);

  localparam int unsigned NE    = NUM_STAGES - ST_EX + 1;
  localparam int unsigned CNT_W = $clog2(MC_LAT) + 1;

  entry_t ent_q [NE];
  entry_t ent_d [NE];
  entry_t id_ent;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic [NE-1:0]          ent_live;
  logic [NE*MAX_AW-1:0]   ent_waddr;
  logic [NE*STAGE_W-1:0]  ent_avail;
  logic [NREAD-1:0]       port_hz;

  logic mc_stall;
  logic flush_eff;
  logic load_hz;

  always_comb begin
    for (int i = 0; i < NE; i++) begin
      ent_live[i]                      = ent_q[i].valid & ent_q[i].we;
      ent_waddr[i*MAX_AW +: MAX_AW]    = ent_q[i].waddr;
      ent_avail[i*STAGE_W +: STAGE_W]  = ent_q[i].avail;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    hazard_fwd_port #(
      .NE     (NE),
      .REG_AW (REG_AW)
    ) u_port (
      .raddr     (id_raddr[p*REG_AW +: REG_AW]),
      .rvalid    (id_rvalid[p]),
      .ent_live  (ent_live),
      .ent_waddr (ent_waddr),
      .ent_avail (ent_avail),
      .sel       (fwd_sel[p*2 +: 2]),
      .hazard    (port_hz[p])
    );
  end

  assign mc_stall  = (cnt_q != '0);
  // A flush held back by a busy divider is applied on the first free cycle.
  assign flush_eff = flush | flush_pend_q;
  // ID is frozen by the multi-cycle stall anyway, so a load-use hit there is masked.
  assign load_hz   = id_valid & (|port_hz) & ~flush_eff & ~mc_stall;

  assign stall_load = load_hz;
  assign mc_busy    = mc_stall;

  always_comb begin
    stall = '0;
    if (mc_stall || load_hz) begin
      stall[ST_PC] = 1'b1;
      stall[ST_IF] = 1'b1;
      stall[ST_ID] = 1'b1;
    end
    if (mc_stall) begin
      stall[ST_EX] = 1'b1;
    end
  end

  always_comb begin
    id_ent.valid = id_valid;
    id_ent.we    = id_we;
    id_ent.waddr = MAX_AW'(id_waddr);
    id_ent.avail = id_ld ? STAGE_W'(LOAD_STAGE) : STAGE_W'(ST_EX);

    ent_d[0] = id_ent;
    for (int i = 1; i < NE; i++) begin
      ent_d[i] = ent_q[i-1];
    end
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;

    if (mc_stall) begin
      ent_d[0]             = ent_q[0];
      ent_d[ST_MEM-ST_EX]  = '0;
      cnt_d                = cnt_q - CNT_W'(1);
      if (flush) begin
        flush_pend_d = 1'b1;
      end
    end else if (flush_eff) begin
      ent_d[0]     = '0;
      flush_pend_d = 1'b0;
    end else if (load_hz) begin
      ent_d[0] = '0;
    end else if (id_valid && id_mc) begin
      // Counts the extra EX cycles beyond the one the op occupies anyway.
      cnt_d = CNT_W'(MC_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: instruction-level pipeline model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_hazard_unit;

  localparam int LS = 4;
  localparam int ML = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_we, id_ld, id_mc, flush;
  logic [9:0] id_raddr;
  logic [1:0] id_rvalid;
  logic [4:0] id_waddr;
  logic [5:0] stall;
  logic [3:0] fwd_sel;
  logic       stall_load, mc_busy;

  int checks   = 0;
  int failures = 0;

  hazard_unit #(
    .NUM_STAGES (5),
    .NREAD      (2),
    .REG_AW     (5),
    .LOAD_STAGE (LS),
    .MC_LAT     (ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_raddr   (id_raddr),
    .id_rvalid  (id_rvalid),
    .id_we      (id_we),
    .id_waddr   (id_waddr),
    .id_ld      (id_ld),
    .id_mc      (id_mc),
    .flush      (flush),
    .stall      (stall),
    .fwd_sel    (fwd_sel),
    .stall_load (stall_load),
    .mc_busy    (mc_busy)
  );

  always #5 clk = ~clk;

  // Model: which instruction occupies each of stages 3..5, and EX cycles left for the one in EX.
  bit   mv [6];
  bit   mwe [6];
  int   mwa [6];
  int   mrdy [6];
  int   ex_rem;
  bit   owed;
  bit   model_ok = 1'b0;

  logic [5:0] exp_stall;
  logic [3:0] exp_fwd;
  logic       exp_sl, exp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_expect();
    logic hz;
    int   ra;
    bit   done;
    hz      = 1'b0;
    exp_fwd = '0;
    for (int p = 0; p < 2; p++) begin
      ra   = int'(id_raddr[p*5 +: 5]);
      done = 1'b0;
      for (int s = 3; s <= 5; s++) begin
        if (!done && id_rvalid[p] && ra != 0 && mv[s] && mwe[s] && mwa[s] == ra) begin
          done = 1'b1;
          if (s >= mrdy[s]) exp_fwd[p*2 +: 2] = 2'((s - 2 > 3) ? 3 : s - 2);
          else hz = 1'b1;
        end
      end
    end
    exp_busy  = (ex_rem > 1);
    exp_sl    = id_valid && hz && !(flush || owed) && !exp_busy;
    exp_stall = exp_busy ? 6'b001111 : (exp_sl ? 6'b000111 : 6'b000000);
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int s = 0; s < 6; s++) mv[s] = 1'b0;
      ex_rem   = 0;
      owed     = 1'b0;
      model_ok = 1'b1;
      return;
    end
    model_expect();
    if (exp_busy) begin
      ex_rem--;
      mv[5] = mv[4]; mwe[5] = mwe[4]; mwa[5] = mwa[4]; mrdy[5] = mrdy[4];
      mv[4] = 1'b0;
      if (flush) owed = 1'b1;
    end else begin
      mv[5] = mv[4]; mwe[5] = mwe[4]; mwa[5] = mwa[4]; mrdy[5] = mrdy[4];
      mv[4] = mv[3]; mwe[4] = mwe[3]; mwa[4] = mwa[3]; mrdy[4] = mrdy[3];
      if (flush || owed) begin
        mv[3] = 1'b0; owed = 1'b0; ex_rem = 0;
      end else if (exp_sl) begin
        mv[3] = 1'b0; ex_rem = 0;
      end else begin
        mv[3]   = id_valid;
        mwe[3]  = id_we;
        mwa[3]  = int'(id_waddr);
        mrdy[3] = id_ld ? LS : 3;
        ex_rem  = id_valid ? (id_mc ? ML : 1) : 0;
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        model_expect();
        chk("cyc_stall", 32'(stall), 32'(exp_stall));
        chk("cyc_fwd_sel", 32'(fwd_sel), 32'(exp_fwd));
        chk("cyc_stall_load", 32'(stall_load), 32'(exp_sl));
        chk("cyc_mc_busy", 32'(mc_busy), 32'(exp_busy));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_id(input logic v, input logic we, input int wa, input logic ld,
                        input logic mc, input int r0, input logic v0, input int r1,
                        input logic v1);
    id_valid  = v;
    id_we     = we;
    id_waddr  = 5'(wa);
    id_ld     = ld;
    id_mc     = mc;
    id_raddr  = {5'(r1), 5'(r0)};
    id_rvalid = {v1, v0};
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_fwd", 32'(fwd_sel), 32'h0);
    chk("reset_stall_load", 32'(stall_load), 32'h0);
    chk("reset_busy", 32'(mc_busy), 32'h0);

    // ALU chain then reads from MEM and WB
    set_id(1, 1, 2, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 3, 0, 0, 2, 1, 2, 1); #2;
    chk("alu_fwd_ex", 32'(fwd_sel), 32'h5);
    chk("alu_stall", 32'(stall), 32'h0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 2, 1); #2;
    chk("alu_fwd_mem", 32'(fwd_sel), 32'h8);
    tick();
    set_id(1, 0, 0, 0, 0, 2, 1, 0, 0); #2;
    chk("alu_fwd_wb", 32'(fwd_sel), 32'h3);
    tick();
    drain();

    // Load-use: one stall cycle, then forward from MEM
    set_id(1, 1, 4, 1, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 5, 0, 0, 4, 1, 0, 1); #2;
    chk("lu_stall", 32'(stall), 32'h07);
    chk("lu_stall_load", 32'(stall_load), 32'h1);
    chk("lu_fwd_hold", 32'(fwd_sel), 32'h0);
    tick(); #2;
    chk("lu_after_stall", 32'(stall), 32'h0);
    chk("lu_after_fwd", 32'(fwd_sel), 32'h2);
    tick();
    drain();

    // Register $0 never forwards or stalls
    set_id(1, 1, 0, 1, 0, 0, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 1); #2;
    chk("r0_stall", 32'(stall), 32'h0);
    chk("r0_fwd", 32'(fwd_sel), 32'h0);
    tick();
    drain();

    // Flush during a load-use hazard
    set_id(1, 1, 6, 1, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 7, 0, 0, 6, 1, 0, 0); flush = 1'b1; #2;
    chk("fl_stall", 32'(stall), 32'h0);
    chk("fl_stall_load", 32'(stall_load), 32'h0);
    tick();
    flush = 1'b0;
    set_id(1, 0, 0, 0, 0, 7, 1, 6, 1); #2;
    chk("fl_fwd", 32'(fwd_sel), 32'h8);
    tick();
    drain();

    // Divider: 7 stall cycles, then the dependent instruction proceeds
    set_id(1, 1, 8, 0, 1, 0, 0, 0, 0); tick();
    set_id(1, 1, 9, 0, 0, 8, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      #2;
      chk("div_stall", 32'(stall), 32'h0f);
      chk("div_busy", 32'(mc_busy), 32'h1);
      if (i == 0) chk("div_fwd", 32'(fwd_sel), 32'h1);
      tick();
    end
    #2;
    chk("div_end_busy", 32'(mc_busy), 32'h0);
    chk("div_end_stall", 32'(stall), 32'h0);
    chk("div_end_fwd", 32'(fwd_sel), 32'h1);
    tick();
    drain();

    // Flush arriving while busy is deferred until the divider frees EX
    set_id(1, 1, 10, 0, 1, 0, 0, 0, 0); tick();
    set_id(1, 1, 11, 0, 0, 10, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      flush = (i == 2);
      #2;
      chk("pend_stall", 32'(stall), 32'h0f);
      tick();
    end
    flush = 1'b0;
    #2;
    chk("pend_apply_stall", 32'(stall), 32'h0);
    tick();
    set_id(1, 0, 0, 0, 0, 11, 1, 10, 1); #2;
    chk("pend_fwd", 32'(fwd_sel), 32'h8);
    tick();
    drain();

    // Reset in the third busy cycle clears everything
    set_id(1, 1, 12, 0, 1, 0, 0, 0, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1; #2;
    chk("rst_div_busy_before", 32'(mc_busy), 32'h1);
    tick();
    rst = 1'b0;
    set_id(1, 0, 0, 0, 0, 12, 1, 12, 1); #2;
    chk("rst_div_stall", 32'(stall), 32'h0);
    chk("rst_div_busy", 32'(mc_busy), 32'h0);
    chk("rst_div_fwd", 32'(fwd_sel), 32'h0);
    tick();
    drain();

    // Mixed traffic checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
